// File: rtl/sysid_check_pkg.sv
// Shared definitions for the system-ID check sequencer.
// State encodings, slave word addresses, counter widths and the word compare helper.
package sysid_check_pkg;

    // Counter widths
    localparam int LAT_W   = 3;
    localparam int RETRY_W = 4;

    // Slave word addresses
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Sequencer states (plain constants for compatibility with older tooling)
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_EVAL = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // True when a captured slave word equals its expected build value
    function automatic logic words_match(input logic [31:0] captured, input logic [31:0] expected);
        words_match = (captured == expected);
    endfunction

endpackage

// File: rtl/sysid_period_timer.sv
// Re-check interval timer for the system-ID sequencer.
// Down-counter that reloads to PERIOD-1 on load and holds at zero;
// expire stays high while the count is zero, until the next load.
// Only instantiated when SYSID_PERIODIC_CHECK_EN is defined.
module sysid_period_timer #(
    parameter int PERIOD = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             expire_r;

    // Next count: reload on request, otherwise count down and stop at zero
    always_comb begin
        cnt_s = cnt_r;
        if (load) begin
            cnt_s = CNT_RELOAD;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_s = cnt_r - CNT_W'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Count register plus a registered expiry flag aligned with a zero count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r    <= CNT_RELOAD;
            expire_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_s;
            expire_r <= (cnt_s == CNT_ZERO);
        end
    end

    assign expire = expire_r;

endmodule

// File: rtl/sysid_check_ctrl.sv
// System-ID check sequencer.
// Reads the ID word (address 0) and build timestamp (address 1) from the
// system-ID slave, compares both against the expected build values, retries
// on mismatch and reports a sticky pass/fail verdict.
// Optional feature macro: SYSID_PERIODIC_CHECK_EN adds a PERIOD-cycle
// re-check timer that launches a check on its own while idle.
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1520875055,
    parameter int          READ_LATENCY = 0,
    parameter int          MAX_RETRY    = 3,
    parameter int          AUTO_START   = 1,
    parameter int          PERIOD       = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count
);

    // Latency counter start value; unused when the slave answers in the strobe cycle
    localparam logic [LAT_W-1:0]   LAT_INIT    = (READ_LATENCY > 0) ? LAT_W'(READ_LATENCY - 1)
                                                                    : {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0]   LAT_ZERO    = {LAT_W{1'b0}};
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    state_t             state_r;
    state_t             state_s;
    logic               addr_r;
    logic [LAT_W-1:0]   lat_cnt_r;
    logic [RETRY_W-1:0] retry_r;
    logic               auto_pend_r;
    logic               pass_r;
    logic               fail_r;
    logic [31:0]        id_r;
    logic [31:0]        ts_r;
    logic               read_r;
    logic               busy_r;
    logic               done_r;

    logic               launch_s;
    logic               capture_s;
    logic               match_s;
    logic               retry_ok_s;
    logic               timer_expire_s;

`ifdef SYSID_PERIODIC_CHECK_EN
    logic timer_load_s;

    // Reload when leaving DONE, and when software asks for a check itself
    assign timer_load_s = (state_r == ST_DONE) || ((state_r == ST_IDLE) && start);

    sysid_period_timer #(
        .PERIOD (PERIOD)
    ) u_period_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (timer_load_s),
        .expire (timer_expire_s)
    );
`else
    // No timer: PERIOD has no effect, it is only referenced so it is not left dangling
    assign timer_expire_s = (PERIOD < 0) ? 1'b1 : 1'b0;
`endif

    // A check starts from IDLE on a start pulse, the post-reset auto start or the timer
    assign launch_s   = (state_r == ST_IDLE) && (start || auto_pend_r || timer_expire_s);
    // Read data is taken in the strobe cycle for zero latency, else when the wait runs out
    assign capture_s  = ((state_r == ST_RD) && (READ_LATENCY == 0)) ||
                        ((state_r == ST_WAIT) && (lat_cnt_r == LAT_ZERO));
    assign match_s    = words_match(id_r, EXPECTED_ID) && words_match(ts_r, EXPECTED_TS);
    assign retry_ok_s = (retry_r < RETRY_LIMIT);

    // Next-state decode of the read/compare sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_s = ST_RD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (READ_LATENCY != 0) begin
                    state_s = ST_WAIT;
                end else if (addr_r == SYSID_ADDR_ID) begin
                    state_s = ST_RD;
                end else begin
                    state_s = ST_EVAL;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_r != LAT_ZERO) begin
                    state_s = ST_WAIT;
                end else if (addr_r == SYSID_ADDR_ID) begin
                    state_s = ST_RD;
                end else begin
                    state_s = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (match_s) begin
                    state_s = ST_DONE;
                end else if (retry_ok_s) begin
                    state_s = ST_RD;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Address, captured words, retry count, latency count and sticky verdict
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_r      <= SYSID_ADDR_ID;
            lat_cnt_r   <= LAT_ZERO;
            retry_r     <= {RETRY_W{1'b0}};
            auto_pend_r <= (AUTO_START != 0);
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            id_r        <= 32'd0;
            ts_r        <= 32'd0;
        end else begin
            // Auto start is offered in the first post-reset cycle only
            auto_pend_r <= 1'b0;

            if (launch_s) begin
                addr_r  <= SYSID_ADDR_ID;
                retry_r <= {RETRY_W{1'b0}};
                pass_r  <= 1'b0;
                fail_r  <= 1'b0;
            end else if (capture_s) begin
                if (addr_r == SYSID_ADDR_ID) begin
                    id_r   <= sysid_readdata;
                    addr_r <= SYSID_ADDR_TS;
                end else begin
                    ts_r   <= sysid_readdata;
                end
            end else if (state_r == ST_EVAL) begin
                if (match_s) begin
                    pass_r <= 1'b1;
                end else if (retry_ok_s) begin
                    retry_r <= retry_r + RETRY_W'(1);
                    addr_r  <= SYSID_ADDR_ID;
                end else begin
                    fail_r <= 1'b1;
                end
            end

            if (state_r == ST_RD) begin
                lat_cnt_r <= LAT_INIT;
            end else if ((state_r == ST_WAIT) && (lat_cnt_r != LAT_ZERO)) begin
                lat_cnt_r <= lat_cnt_r - LAT_W'(1);
            end
        end
    end

    // Registered strobes: each reflects the state being entered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            read_r <= (state_s == ST_RD);
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
        end
    end

    assign sysid_address = addr_r;
    assign sysid_read    = read_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign fail          = fail_r;
    assign id_value      = id_r;
    assign ts_value      = ts_r;
    assign retry_count   = retry_r;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl.
// dut0: zero read latency, auto start. dut2: read latency 2, manual start.
// dut3 (only with SYSID_PERIODIC_CHECK_EN): periodic re-check every 20 cycles.
module tb_sysid_check_ctrl;

    localparam logic [31:0] GOOD_ID = 32'd0;
    localparam logic [31:0] GOOD_TS = 32'd1520875055;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // ---------------- dut0: READ_LATENCY=0, AUTO_START=1 ----------------
    logic        rst0, start0, addr0, read0, busy0, done0, pass0, fail0;
    logic [31:0] rdata0, idv0, tsv0, id_w0, ts_w0;
    logic [3:0]  rc0;
    assign rdata0 = addr0 ? ts_w0 : id_w0;

    sysid_check_ctrl #(
        .READ_LATENCY (0), .MAX_RETRY (3), .AUTO_START (1)
    ) dut0 (
        .clock (clk), .reset (rst0), .start (start0),
        .sysid_address (addr0), .sysid_read (read0), .sysid_readdata (rdata0),
        .busy (busy0), .done (done0), .pass (pass0), .fail (fail0),
        .id_value (idv0), .ts_value (tsv0), .retry_count (rc0)
    );

    // ---------------- dut2: READ_LATENCY=2, AUTO_START=0 ----------------
    logic        rst2, start2, addr2, read2, busy2, done2, pass2, fail2;
    logic [31:0] rdata2, idv2, tsv2, pipe1, pipe2;
    logic [3:0]  rc2;
    // Slave model: data appears two cycles after the strobe
    always @(posedge clk) begin
        pipe1 <= read2 ? (addr2 ? GOOD_TS : GOOD_ID) : 32'hFFFF_FFFF;
        pipe2 <= pipe1;
    end
    assign rdata2 = pipe2;

    sysid_check_ctrl #(
        .READ_LATENCY (2), .MAX_RETRY (3), .AUTO_START (0)
    ) dut2 (
        .clock (clk), .reset (rst2), .start (start2),
        .sysid_address (addr2), .sysid_read (read2), .sysid_readdata (rdata2),
        .busy (busy2), .done (done2), .pass (pass2), .fail (fail2),
        .id_value (idv2), .ts_value (tsv2), .retry_count (rc2)
    );

`ifdef SYSID_PERIODIC_CHECK_EN
    logic        rst3, start3, addr3, read3, busy3, done3, pass3, fail3;
    logic [31:0] rdata3, idv3, tsv3, ts_w3;
    logic [3:0]  rc3;
    assign rdata3 = addr3 ? ts_w3 : GOOD_ID;

    sysid_check_ctrl #(
        .READ_LATENCY (0), .MAX_RETRY (3), .AUTO_START (1), .PERIOD (20)
    ) dut3 (
        .clock (clk), .reset (rst3), .start (start3),
        .sysid_address (addr3), .sysid_read (read3), .sysid_readdata (rdata3),
        .busy (busy3), .done (done3), .pass (pass3), .fail (fail3),
        .id_value (idv3), .ts_value (tsv3), .retry_count (rc3)
    );
`endif

    // Event counters: a strobe seen in a cycle is counted at the edge ending it
    int nrd0 = 0, ndn0 = 0, nrd2 = 0, ndn2 = 0;
    always @(posedge clk) begin
        if (read0) nrd0 <= nrd0 + 1;
        if (done0) ndn0 <= ndn0 + 1;
        if (read2) nrd2 <= nrd2 + 1;
        if (done2) ndn2 <= ndn2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample mid-cycle
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Cycles until dut0 pulses done (0 if it never does within the budget)
    task automatic wait_done0(input int maxc, output int k);
        k = 0;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (done0) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, r1, r2, dk, brd, bdn;
        rst0 = 1'b1; rst2 = 1'b1; start0 = 1'b0; start2 = 1'b0;
        id_w0 = GOOD_ID; ts_w0 = GOOD_TS;
`ifdef SYSID_PERIODIC_CHECK_EN
        rst3 = 1'b1; start3 = 1'b0; ts_w3 = GOOD_TS;
`endif
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy", busy0, 32'd0);
        chk("rst_read", read0, 32'd0);
        chk("rst_addr", addr0, 32'd0);
        chk("rst_pass_fail", {pass0, fail0, done0}, 32'd0);
        chk("rst_values", idv0 | tsv0 | rc0, 32'd0);

        // Test 1: auto start, reads in cycles 1 and 2, done in cycle 4
        rst0 = 1'b0; rst2 = 1'b0;           // this is cycle 0
        chk("t1_c0_read", read0, 32'd0);
        step();                              // cycle 1
        chk("t1_c1_read", {read0, addr0, busy0}, 32'b101);
        step();                              // cycle 2
        chk("t1_c2_read", {read0, addr0}, 32'b11);
        step();                              // cycle 3
        chk("t1_c3_idle_bus", {read0, done0}, 32'b00);
        step();                              // cycle 4
        chk("t1_c4_done", done0, 32'd1);
        step();                              // cycle 5
        chk("t1_done_width", done0, 32'd0);
        chk("t1_pass_fail", {pass0, fail0}, 32'b10);
        chk("t1_retry", rc0, 32'd0);
        chk("t1_ts_value", tsv0, GOOD_TS);
        chk("t1_busy_after", busy0, 32'd0);

        // Test 3: wrong ID every time -> 4 attempts, 8 strobes, fail
        // done lands 4 + 3*3 = 13 cycles after the start cycle
        id_w0 = 32'hDEAD; brd = nrd0; bdn = ndn0;
        start0 = 1'b1; step(); start0 = 1'b0;
        wait_done0(40, k);
        chk("t3_done_cycle", k + 1, 32'd13);
        step(); step();
        chk("t3_strobes", nrd0 - brd, 32'd8);
        chk("t3_done_count", ndn0 - bdn, 32'd1);
        chk("t3_pass_fail", {pass0, fail0}, 32'b01);
        chk("t3_retry", rc0, 32'd3);
        chk("t3_id_value", idv0, 32'hDEAD);

        // Test 4: first TS wrong, fixed during EVAL -> one retry, pass
        // done at 4 + 3 = 7 cycles after start
        id_w0 = GOOD_ID; ts_w0 = 32'h1234_5678; bdn = ndn0;
        start0 = 1'b1; step(); start0 = 1'b0;  // cycle 1
        step(); step();                         // cycle 3 (EVAL), TS already captured
        chk("t4_bad_ts_captured", tsv0, 32'h1234_5678);
        ts_w0 = GOOD_TS;
        wait_done0(40, k);
        chk("t4_done_cycle", k + 3, 32'd7);
        repeat (3) step();
        chk("t4_retry", rc0, 32'd1);
        chk("t4_pass_fail", {pass0, fail0}, 32'b10);
        chk("t4_done_count", ndn0 - bdn, 32'd1);

        // Test 2: latency 2 -> strobes at cycles 1 and 4, done at 8
        r1 = 0; r2 = 0; dk = 0;
        start2 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            start2 = 1'b0;
            if (read2) begin
                if (r1 == 0) r1 = c;
                else if (r2 == 0) r2 = c;
            end
            if (done2 && dk == 0) dk = c;
        end
        chk("t2_first_read", r1, 32'd1);
        chk("t2_second_read", r2, 32'd4);
        chk("t2_done_cycle", dk, 32'd8);
        chk("t2_pass_fail", {pass2, fail2}, 32'b10);
        chk("t2_values", tsv2, GOOD_TS);

        // Start while busy is dropped
        brd = nrd2; bdn = ndn2;
        start2 = 1'b1; step(); start2 = 1'b0;
        step(); start2 = 1'b1; step(); start2 = 1'b0;
        repeat (14) step();
        chk("busy_start_strobes", nrd2 - brd, 32'd2);
        chk("busy_start_dones", ndn2 - bdn, 32'd1);
        chk("busy_start_idle", busy2, 32'd0);

        // Test 5: extra start in RD, then reset in WAIT aborts the check
        brd = nrd2; bdn = ndn2;
        start2 = 1'b1; step();               // cycle 1: RD, start still high
        step(); start2 = 1'b0;               // cycle 2: WAIT
        chk("t5_busy_before", busy2, 32'd1);
        rst2 = 1'b1;
        #1;
        chk("t5_async_outputs", {read2, busy2, done2}, 32'b000);
        chk("t5_pass_fail", {pass2, fail2}, 32'b00);
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        repeat (12) step();
        chk("t5_no_done", ndn2 - bdn, 32'd0);
        chk("t5_one_strobe", nrd2 - brd, 32'd1);
        chk("t5_idle_after", {busy2, pass2, fail2}, 32'b000);

`ifdef SYSID_PERIODIC_CHECK_EN
        // Test 6: periodic re-check 20 cycles after DONE, now with bad TS
        rst3 = 1'b0;                         // cycle 0
        dk = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (done3 && dk == 0) dk = c;
        end
        chk("t6_first_done", dk, 32'd4);
        chk("t6_first_pass", pass3, 32'd1);
        ts_w3 = 32'h0BAD_0BAD;
        r1 = 0;
        for (int c = 7; c <= 30; c++) begin
            step();
            if (read3 && r1 == 0) r1 = c;
        end
        chk("t6_second_read", r1, 32'd25);
        dk = 0;
        for (int c = 31; c <= 60; c++) begin
            step();
            if (done3 && dk == 0) dk = c;
        end
        chk("t6_second_done", dk, 32'd37);
        step();
        chk("t6_pass_fail", {pass3, fail3}, 32'b01);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
